// File: rtl/univ_shift_reg_param.sv
// univ_shift_reg_param
//   Universal shift register, WIDTH bits wide, with an auto-serialize engine
//   that loads a word and shifts it out LSB-first over WIDTH enabled cycles.
//
// Ports
//   clk         clock, rising-edge
//   rst         synchronous active-high reset
//   en          clock enable for mode operations and serialize shifts
//   mode        register operation select (honoured only when idle)
//   din         parallel load data (mode load and start)
//   ser_in_lo   serial input into bit 0 on shift up
//   ser_in_hi   serial input into the MSB on shift down / serialize
//   start       single-cycle request to begin serializing din
//   q           register contents
//   ser_out_lo  q[0]
//   ser_out_hi  q[WIDTH-1]
//   busy        serialize burst in progress
//   done        one-cycle pulse after the last serialize shift
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | register follows mode when en=1; start begins a burst
// ST_SHIFT | serialize burst; shifts down on en, mode/start ignored
module univ_shift_reg_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in_lo,
    input  logic             ser_in_hi,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lo,
    output logic             ser_out_hi,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start wins over mode and does not need en
                    q_d     = din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                end else if (en) begin
                    case (mode)
                        MODE_HOLD:  q_d = q_q;
                        MODE_SHL:   q_d = {q_q[WIDTH-2:0], ser_in_lo};
                        MODE_SHR:   q_d = {ser_in_hi, q_q[WIDTH-1:1]};
                        MODE_LOAD:  q_d = din;
                        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                        MODE_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                        MODE_CLEAR: q_d = '0;
                        default:    q_d = q_q;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    q_d   = {ser_in_hi, q_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q          = q_q;
    assign ser_out_lo = q_q[0];
    assign ser_out_hi = q_q[WIDTH-1];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Testbench for univ_shift_reg_param (WIDTH=8): directed plan plus random
// stimulus, checked by a scoreboard fed from a behavioural model.
module tb_univ_shift_reg_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] din = '0;
    logic         ser_in_lo = 1'b0;
    logic         ser_in_hi = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] q;
    logic         ser_out_lo, ser_out_hi, busy, done;

    univ_shift_reg_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
        .ser_in_lo(ser_in_lo), .ser_in_hi(ser_in_hi), .start(start),
        .q(q), .ser_out_lo(ser_out_lo), .ser_out_hi(ser_out_hi),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        bit           busy;
        bit           done;
        bit           has_c;
        logic [W-1:0] cq;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // behavioural model: register value, burst flag, shifts remaining
    logic [W-1:0] m_q = '0;
    bit           m_busy = 0;
    bit           m_done = 0;
    int           m_left = 0;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [2:0] m,
                        input logic [W-1:0] d, input bit lo, input bit hi,
                        input bit s, input bit hc, input logic [W-1:0] c,
                        input string nm);
        exp_t x;
        rst = r; en = e; mode = m; din = d;
        ser_in_lo = lo; ser_in_hi = hi; start = s;
        m_done = 0;
        if (r) begin
            m_q = '0; m_busy = 0; m_left = 0;
        end else if (m_busy) begin
            if (e) begin
                m_q = (m_q >> 1) | (W'(hi) << (W - 1));
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (s) begin
            m_q = d; m_busy = 1; m_left = W;
        end else if (e) begin
            case (m)
                3'd1: m_q = (m_q << 1) | W'(lo);
                3'd2: m_q = (m_q >> 1) | (W'(hi) << (W - 1));
                3'd3: m_q = d;
                3'd4: m_q = (m_q << 1) | (m_q >> (W - 1));
                3'd5: m_q = (m_q >> 1) | (m_q << (W - 1));
                3'd6: m_q = (m_q >> 1) | (m_q & (W'(1) << (W - 1)));
                3'd7: m_q = '0;
                default: m_q = m_q;
            endcase
        end
        x.q = m_q; x.busy = m_busy; x.done = m_done;
        x.has_c = hc; x.cq = c; x.name = nm;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] m, input logic [W-1:0] d, input bit lo,
                      input bit hi, input logic [W-1:0] c, input string nm);
        step(0, 1, m, d, lo, hi, 0, 1, c, nm);
    endtask

    // monitor: one scoreboard entry per clock edge after stimulus begins
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk({x.name, " q"}, q, x.q);
                chk({x.name, " busy"}, W'(busy), W'(x.busy));
                chk({x.name, " done"}, W'(done), W'(x.done));
                chk({x.name, " ser_out_lo"}, W'(ser_out_lo), W'(x.q[0]));
                chk({x.name, " ser_out_hi"}, W'(ser_out_hi), W'(x.q[W-1]));
                if (x.has_c) chk({x.name, " q plan"}, q, x.cq);
            end
        end
    end

    // Runs one burst. stall_at: first of two en=0 cycles (0 = none);
    // restart_at: busy cycle on which start is re-asserted (0 = none);
    // abort_at: busy cycle on which rst is asserted (0 = none).
    task automatic run_burst(input logic [W-1:0] d, input int stall_at,
                             input int restart_at, input int abort_at,
                             input int exp_busy, input int exp_done,
                             input bit check_bits, input string nm);
        int n = 0;
        int dn = 0;
        logic [W-1:0] bits = '0;
        bit e;
        step(0, 1, 3'd3, d, 0, 0, 1, 1, d, {nm, " load"});
        while (busy && n < 40) begin
            if (n < W) bits[n] = ser_out_lo;
            n++;
            e = !(stall_at != 0 && (n == stall_at || n == stall_at + 1));
            if (n == abort_at)
                step(1, 1, 3'd3, '1, 0, 0, 0, 1, '0, {nm, " abort"});
            else
                step(0, e, 3'd3, n[0] ? '1 : '0, 0, 0, n == restart_at,
                     0, '0, {nm, " shift"});
            if (done) dn++;
        end
        step(0, 0, 3'd0, '0, 0, 0, 0, 0, '0, {nm, " tail"});
        if (done) dn++;
        chk({nm, " busy cycles"}, W'(n), W'(exp_busy));
        chk({nm, " done pulses"}, W'(dn), W'(exp_done));
        if (check_bits) chk({nm, " ser_out_lo bits"}, bits, d);
    endtask

    initial begin
        int wait_n;
        @(negedge clk);

        // reset and load
        step(1, 1, 3'd3, 8'hFF, 0, 0, 0, 1, 8'h00, "reset0");
        step(1, 1, 3'd3, 8'hFF, 0, 0, 0, 1, 8'h00, "reset1");
        op(3'd3, 8'hA5, 0, 0, 8'hA5, "load A5");

        // rotate
        op(3'd5, 8'h00, 0, 0, 8'hD2, "ror");
        op(3'd3, 8'hA5, 0, 0, 8'hA5, "reload A5");
        op(3'd4, 8'h00, 0, 0, 8'h4B, "rol");
        step(0, 0, 3'd4, 8'h00, 0, 0, 0, 1, 8'h4B, "en0 hold");

        // arithmetic shift and clear
        op(3'd3, 8'h90, 0, 0, 8'h90, "load 90");
        op(3'd6, 8'h00, 0, 0, 8'hC8, "asr1");
        op(3'd6, 8'h00, 0, 0, 8'hE4, "asr2");
        op(3'd7, 8'h00, 0, 0, 8'h00, "clear");

        // logical shifts
        op(3'd1, 8'h00, 1, 0, 8'h01, "shl1");
        op(3'd1, 8'h00, 1, 0, 8'h03, "shl2");
        op(3'd1, 8'h00, 1, 0, 8'h07, "shl3");
        op(3'd7, 8'h00, 0, 0, 8'h00, "clear2");
        op(3'd2, 8'h00, 0, 1, 8'h80, "shr1");
        op(3'd2, 8'h00, 0, 1, 8'hC0, "shr2");

        // auto-serialize
        run_burst(8'h3C, 0, 0, 0, 8, 1, 1, "burst");
        run_burst(8'h3C, 4, 0, 0, 10, 1, 0, "stall");
        run_burst(8'h5A, 0, 3, 0, 8, 1, 1, "restart ignored");
        run_burst(8'hC3, 0, 0, 4, 4, 0, 0, "abort");
        step(0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 8'h00, "post abort");
        run_burst(8'h81, 0, 0, 0, 8, 1, 1, "fresh");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), W'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 7) == 0, 0, '0, "rand");
        end

        wait_n = 0;
        while (sb.size() > 0 && wait_n < 5) begin
            @(negedge clk);
            wait_n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg_param.md
Name: univ_shift_reg_param

Overview:
- Parametrised universal shift register, WIDTH bits wide.
- Eight register modes: hold, logical shift up and down, parallel load, rotate up and down, arithmetic shift down, clear.
- Built-in auto-serialize engine: loads a word and shifts it out LSB-first over WIDTH enabled cycles, with busy and done status.
- Serves as the general-purpose shift/serializer primitive for datapath and serial-link blocks in the design.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable for mode operations and for auto-serialize shifts.
- mode  input  3  operation select, IDLE state only (encoding in Behaviour).
- din  input  WIDTH  parallel load data, used by mode 011 and by start.
- ser_in_lo  input  1  serial input into bit 0 for shift up.
- ser_in_hi  input  1  serial input into bit WIDTH-1 for shift down and auto-serialize.
- start  input  1  single-cycle request to begin auto-serialize of din.
- q  output  WIDTH  register contents.
- ser_out_lo  output  1  equals q[0].
- ser_out_hi  output  1  equals q[WIDTH-1].
- busy  output  1  high while auto-serialize is active.
- done  output  1  one-cycle pulse when auto-serialize completes.

Behaviour:
- Reset: rst sampled high at an edge gives q=0, busy=0, done=0, state=IDLE and count=0. Reset has priority over all other inputs and aborts a burst in progress with no done pulse.
- Two-state FSM: IDLE and SHIFT. Internal counter cnt is $clog2(WIDTH+1) bits.
- IDLE with start=1: q<=din, cnt<=0, state goes to SHIFT, busy<=1. This happens regardless of en and overrides mode.
- IDLE with start=0 and en=1, per mode:
  - 000 hold.
  - 001 shift up: q<={q[WIDTH-2:0],ser_in_lo}.
  - 010 shift down: q<={ser_in_hi,q[WIDTH-1:1]}.
  - 011 load: q<=din.
  - 100 rotate up: q<={q[WIDTH-2:0],q[WIDTH-1]}.
  - 101 rotate down: q<={q[0],q[WIDTH-1:1]}.
  - 110 arithmetic shift down: q<={q[WIDTH-1],q[WIDTH-1:1]}.
  - 111 clear: q<=0.
- IDLE with en=0: q holds.
- SHIFT state:
  - mode is ignored and start is ignored (no restart, no queuing).
  - With en=1: shift down with ser_in_hi into the MSB, cnt<=cnt+1.
  - With en=0: q and cnt hold; busy stays high.
  - On the shift where cnt==WIDTH-1: state goes to IDLE, busy<=0 and done<=1 for exactly one cycle.
- Burst timing:
  - Bit k of din appears on ser_out_lo after the load edge plus k enabled shifts, k = 0 to WIDTH-1.
  - With en held high, busy is high for exactly WIDTH cycles and done asserts in the cycle after busy falls.
  - done is 0 in every other cycle.
- start on the same edge that done is set (returning to IDLE) is ignored; a new start is accepted from the next cycle.
- All outputs are registered or direct wiring of q. There is no combinational path from inputs to outputs.

Test Plan (WIDTH=8):
1. Reset and load:
   - rst=1 for 2 cycles with din=FF and mode=011 -> q=00, busy=0, done=0.
   - Release rst, en=1, mode=011, din=A5 -> q=A5 after 1 edge.
2. Rotate:
   - From q=A5, mode=101 -> D2.
   - Reload A5, mode=100 -> 4B.
   - en=0 with mode=100 -> q holds 4B.
3. Arithmetic shift:
   - Load 90, mode=110 for 2 edges -> C8 then E4.
   - mode=111 -> 00.
4. Logical shift:
   - From 00, mode=001, ser_in_lo=1 for 3 edges -> 01, 03, 07.
   - From 00, mode=010, ser_in_hi=1 -> 80, C0.
5. Auto-serialize:
   - start with din=3C, en=1, ser_in_hi=0, mode=011 toggling with din=FF -> busy high for 8 cycles.
   - ser_out_lo sequence is 0,0,1,1,1,1,0,0; done pulses once; q=00 afterwards.
   - Repeat with en=0 for 2 mid-burst cycles -> busy high for 10 cycles, same bit sequence with the held bit stretched.
6. Abort and restart rules:
   - start during a burst is ignored (sequence unchanged).
   - rst asserted on the 4th busy cycle -> next cycle q=00, busy=0, no done pulse.
   - A fresh start after reset serializes correctly.
